// File: rtl/fu_req_fifo_pkg.sv
// rtl/fu_req_fifo_pkg.sv - shared issue-stage types: function-unit classes and the issue packet
// Every FU buffer and the issue logic import these definitions so packet layout stays in one place.
package fu_req_fifo_pkg;

  localparam int ROB_W = 6;
  localparam int OPC_W = 4;
  localparam int OPD_W = 16;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_type_e;

  typedef struct packed {
    logic             valid;
    fu_type_e         fu_type;
    logic [ROB_W-1:0] rob_idx;
    logic [OPC_W-1:0] opcode;
    logic [OPD_W-1:0] operand;
  } issue_packet_t;

endpackage

// File: rtl/fu_req_fifo.sv
// rtl/fu_req_fifo.sv - per-FU request buffer between issue logic and one function unit
// Circular packet store with registered ready, flush squash and sticky overflow/misroute flags.
module fu_req_fifo
  import fu_req_fifo_pkg::*;
#(
  parameter int       DEPTH   = 4,
  parameter fu_type_e FU_KIND = FU_ALU
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  issue_packet_t              req_i,
  output logic                       ready_o,
  output logic [$clog2(DEPTH+1)-1:0] free_slots_o,
  output issue_packet_t              fu_pkt_o,
  output logic                       fu_valid_o,
  input  logic                       fu_ready_i,
  input  logic                       flush_i,
  output logic                       overflow_o,
  output logic                       misroute_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  issue_packet_t mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          misroute_q, misroute_d;
  logic          type_ok;
  logic          enq;
  logic          deq;

  // DEPTH need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign ready_o      = (count_q < CW'(DEPTH));
  assign free_slots_o = CW'(DEPTH) - count_q;
  assign fu_valid_o   = (count_q != '0);
  assign overflow_o   = overflow_q;
  assign misroute_o   = misroute_q;

  assign type_ok = (req_i.fu_type == FU_KIND);
  assign enq     = req_i.valid && ready_o && type_ok && !flush_i;
  assign deq     = fu_valid_o && fu_ready_i && !flush_i;

  always_comb begin
    fu_pkt_o       = mem_q[head_q];
    fu_pkt_o.valid = fu_valid_o;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (req_i.valid & ~ready_o);
    misroute_d = misroute_q | (req_i.valid & ~type_ok);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = ptr_inc(tail_q);
      if (deq) head_d = ptr_inc(head_q);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misroute_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      misroute_q <= misroute_d;
    end
  end

  // Storage is unreset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= req_i;
  end

endmodule

// File: tb/tb_fu_req_fifo.sv
// tb/tb_fu_req_fifo.sv - directed self-checking bench for fu_req_fifo at DEPTH=4, FU_KIND=FU_ALU
module tb_fu_req_fifo;
  import fu_req_fifo_pkg::*;

  logic          clk;
  logic          reset_n;
  issue_packet_t req_i;
  logic          ready_o;
  logic [2:0]    free_slots_o;
  issue_packet_t fu_pkt_o;
  logic          fu_valid_o;
  logic          fu_ready_i;
  logic          flush_i;
  logic          overflow_o;
  logic          misroute_o;

  int total;
  int bad;
  int exp_q[$];

  fu_req_fifo #(.DEPTH(4), .FU_KIND(FU_ALU)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        (req_i),
    .ready_o      (ready_o),
    .free_slots_o (free_slots_o),
    .fu_pkt_o     (fu_pkt_o),
    .fu_valid_o   (fu_valid_o),
    .fu_ready_i   (fu_ready_i),
    .flush_i      (flush_i),
    .overflow_o   (overflow_o),
    .misroute_o   (misroute_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_packet_t mk(input fu_type_e t, input int rob);
    issue_packet_t p;
    p.valid   = 1'b1;
    p.fu_type = t;
    p.rob_idx = ROB_W'(rob);
    p.opcode  = OPC_W'(rob + 3);
    p.operand = OPD_W'(rob * 257);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_i      = '0;
    fu_ready_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    total++; if (fu_valid_o !== 1'b0) begin bad++; $display("FAIL reset_fu_valid got=%b want=0", fu_valid_o); end
    total++; if (fu_pkt_o.valid !== 1'b0) begin bad++; $display("FAIL reset_pkt_valid got=%b want=0", fu_pkt_o.valid); end
    total++; if (free_slots_o !== 3'd4) begin bad++; $display("FAIL reset_free got=%0d want=4", free_slots_o); end
    total++; if (overflow_o !== 1'b0 || misroute_o !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", overflow_o, misroute_o); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      req_i = mk(FU_ALU, i);
      if (i == 1) begin
        total++; if (fu_valid_o !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b want=0", fu_valid_o); end
      end
      step();
      if (i == 1) begin
        total++; if (fu_valid_o !== 1'b1 || fu_pkt_o.rob_idx !== 6'd1) begin bad++; $display("FAIL first_latency got=%b/%0d want=1/1", fu_valid_o, fu_pkt_o.rob_idx); end
      end
    end
    idle();
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready_o); end
    total++; if (free_slots_o !== 3'd0) begin bad++; $display("FAIL full_free got=%0d want=0", free_slots_o); end
    total++; if (fu_pkt_o.rob_idx !== 6'd1 || fu_pkt_o.opcode !== 4'd4 || fu_pkt_o.operand !== 16'd257) begin bad++; $display("FAIL full_head got=%0d/%0d/%0d want=1/4/257", fu_pkt_o.rob_idx, fu_pkt_o.opcode, fu_pkt_o.operand); end
  endtask

  task automatic test_full_overflow();
    req_i      = mk(FU_ALU, 9);
    fu_ready_i = 1'b1;
    step();
    idle();
    total++; if (fu_pkt_o.rob_idx !== 6'd2) begin bad++; $display("FAIL ovf_head got=%0d want=2", fu_pkt_o.rob_idx); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_o); end
    total++; if (ready_o !== 1'b1 || free_slots_o !== 3'd1) begin bad++; $display("FAIL ovf_reopen got=%b/%0d want=1/1", ready_o, free_slots_o); end
    total++; if (misroute_o !== 1'b0) begin bad++; $display("FAIL ovf_misroute got=%b want=0", misroute_o); end
  endtask

  task automatic test_back_to_back();
    fu_ready_i = 1'b1;
    step();
    idle();
    total++; if (free_slots_o !== 3'd2 || fu_pkt_o.rob_idx !== 6'd3) begin bad++; $display("FAIL b2b_setup got=%0d/%0d want=2/3", free_slots_o, fu_pkt_o.rob_idx); end
    exp_q = '{3, 4};
    for (int k = 0; k < 10; k++) begin
      int e;
      e = exp_q.pop_front();
      total++; if (fu_valid_o !== 1'b1 || fu_pkt_o.rob_idx !== ROB_W'(e)) begin bad++; $display("FAIL b2b_order k=%0d got=%0d want=%0d", k, fu_pkt_o.rob_idx, e); end
      req_i      = mk(FU_ALU, 20 + k);
      fu_ready_i = 1'b1;
      exp_q.push_back(20 + k);
      step();
      total++; if (free_slots_o !== 3'd2) begin bad++; $display("FAIL b2b_count k=%0d got=%0d want=2", k, free_slots_o); end
    end
    idle();
    total++; if (fu_pkt_o.rob_idx !== 6'd28) begin bad++; $display("FAIL b2b_tail_head got=%0d want=28", fu_pkt_o.rob_idx); end
  endtask

  task automatic test_flush();
    req_i = mk(FU_ALU, 40);
    step();
    idle();
    total++; if (free_slots_o !== 3'd1) begin bad++; $display("FAIL flush_setup got=%0d want=1", free_slots_o); end
    flush_i    = 1'b1;
    req_i      = mk(FU_ALU, 41);
    fu_ready_i = 1'b1;
    #1;
    total++; if (fu_valid_o !== 1'b1) begin bad++; $display("FAIL flush_prestate got=%b want=1", fu_valid_o); end
    step();
    idle();
    total++; if (fu_valid_o !== 1'b0 || free_slots_o !== 3'd4 || ready_o !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b/%0d/%b want=0/4/1", fu_valid_o, free_slots_o, ready_o); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL flush_sticky got=%b want=1", overflow_o); end
    req_i = mk(FU_ALU, 50);
    step();
    idle();
    total++; if (fu_pkt_o.rob_idx !== 6'd50 || free_slots_o !== 3'd3) begin bad++; $display("FAIL flush_noenq got=%0d/%0d want=50/3", fu_pkt_o.rob_idx, free_slots_o); end
  endtask

  task automatic test_misroute();
    req_i = mk(FU_MUL, 60);
    step();
    idle();
    total++; if (misroute_o !== 1'b1) begin bad++; $display("FAIL misroute_flag got=%b want=1", misroute_o); end
    total++; if (free_slots_o !== 3'd3 || fu_pkt_o.rob_idx !== 6'd50) begin bad++; $display("FAIL misroute_drop got=%0d/%0d want=3/50", free_slots_o, fu_pkt_o.rob_idx); end
  endtask

  task automatic test_async_reset();
    req_i = mk(FU_ALU, 61);
    step();
    idle();
    total++; if (free_slots_o !== 3'd2) begin bad++; $display("FAIL areset_setup got=%0d want=2", free_slots_o); end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (fu_valid_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL areset_now got=%b/%b want=0/1", fu_valid_o, ready_o); end
    total++; if (overflow_o !== 1'b0 || misroute_o !== 1'b0) begin bad++; $display("FAIL areset_flags got=%b%b want=00", overflow_o, misroute_o); end
    total++; if (free_slots_o !== 3'd4) begin bad++; $display("FAIL areset_free got=%0d want=4", free_slots_o); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total++; if (fu_valid_o !== 1'b0) begin bad++; $display("FAIL areset_after got=%b want=0", fu_valid_o); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_full_overflow();
    test_back_to_back();
    test_flush();
    test_misroute();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
